// File: rtl/fifo_uart_drain.sv
// -----------------------------------------------------------------------------
// fifo_uart_drain
//
// Drains 8-bit ADC samples from the sample FIFO and sends each one as an
// asynchronous UART frame (start, 8 data bits LSB first, optional even parity,
// one stop bit). Exactly one FIFO pop is issued per transmitted byte. A single
// per-bit baud counter sets the bit time; there is no oversampling and no
// receive path.
//
// Optional feature macro: UART_PARITY_EN
//   defined   -> an even-parity bit is inserted between the data bits and the
//                stop bit (11 bit times per frame)
//   undefined -> plain 8N1 (10 bit times per frame)
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit, legal range 2..65535
//   CNT_W         width of the completed-frame counter
//
// Ports
//   i_clk          system clock, all logic on the rising edge
//   i_rst          synchronous active-high reset
//   i_enable       when low no new byte is started; a frame in flight completes
//   i_fifo_empty   FIFO empty flag
//   i_fifo_dout    FIFO read data, valid the cycle after o_fifo_pop
//   o_fifo_pop     single-cycle FIFO pop strobe
//   o_tx           UART serial line, idle high
//   o_busy         high from the pop cycle through the last stop-bit cycle
//   o_byte_done    single-cycle pulse on the last stop-bit cycle
//   o_bytes_sent   completed frames, wraps modulo 2^CNT_W
//
// Every output is a flop. Each flop is loaded from the next-state decode, so
// the pop decision is taken from enable/empty as seen on the edge that opens
// the pop cycle (the edge leaving an idle cycle, or the edge leaving the last
// stop-bit cycle for back-to-back frames). Pop-to-start-bit spacing is
// therefore still two cycles and consecutive frames are separated by exactly
// two idle-high cycles.
// -----------------------------------------------------------------------------
module fifo_uart_drain #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_fifo_empty,
  input  logic [7:0]       i_fifo_dout,
  output logic             o_fifo_pop,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_byte_done,
  output logic [CNT_W-1:0] o_bytes_sent
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

`ifdef UART_PARITY_EN
  // Even parity: the transmitted bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    even_parity = ^data;
  endfunction
`endif

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                r_pop;
  logic                r_tx;
  logic                r_busy;
  logic                r_byte_done;
  logic [CNT_W-1:0]    r_bytes_sent;

  state_t              w_state_next;
  logic [BAUD_W-1:0]   w_baud_next;
  logic [2:0]          w_bit_next;
  logic [7:0]          w_shift_next;
  logic                w_pop_next;
  logic                w_tx_next;
  logic                w_busy_next;
  logic                w_done_next;
  logic                w_bit_end;
  logic                w_start_ok;

  assign w_bit_end  = (r_baud == BAUD_LAST);
  assign w_start_ok = i_enable & ~i_fifo_empty;

  // Next-state, baud counter, bit index, shift register and pop decision.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_pop_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pop) begin
          // This is the pop cycle; the FIFO presents data during FETCH.
          w_state_next = S_FETCH;
        end else begin
          w_pop_next = w_start_ok;
        end
      end
      S_FETCH: begin
        w_shift_next = i_fifo_dout;
        w_baud_next  = BAUD_ZERO;
        w_bit_next   = 3'd0;
        w_state_next = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_next  = BAUD_ZERO;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next = BAUD_ZERO;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_baud_next  = BAUD_ZERO;
          w_state_next = S_STOP;
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next  = BAUD_ZERO;
          w_state_next = S_IDLE;
          // Back-to-back: the first idle cycle after the stop bit is the pop.
          w_pop_next   = w_start_ok;
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = BAUD_ZERO;
        w_bit_next   = 3'd0;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight off a flop.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[w_bit_next];
`ifdef UART_PARITY_EN
      S_PARITY: w_tx_next = even_parity(w_shift_next);
`endif
      default:  w_tx_next = 1'b1;
    endcase
    w_busy_next = w_pop_next | (w_state_next != S_IDLE);
    w_done_next = (w_state_next == S_STOP) & (w_baud_next == BAUD_LAST);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_baud       <= BAUD_ZERO;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_pop        <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_byte_done  <= 1'b0;
      r_bytes_sent <= CNT_ZERO;
    end else begin
      r_state     <= w_state_next;
      r_baud      <= w_baud_next;
      r_bit_idx   <= w_bit_next;
      r_shift     <= w_shift_next;
      r_pop       <= w_pop_next;
      r_tx        <= w_tx_next;
      r_busy      <= w_busy_next;
      r_byte_done <= w_done_next;
      if (w_done_next) begin
        r_bytes_sent <= r_bytes_sent + CNT_ONE;
      end else begin
        r_bytes_sent <= r_bytes_sent;
      end
    end
  end

  assign o_fifo_pop   = r_pop;
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_byte_done  = r_byte_done;
  assign o_bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Self-checking bench for fifo_uart_drain (CLKS_PER_BIT=4, CNT_W=2).
// A FIFO model feeds the DUT; bytes are pushed into a scoreboard queue as they
// are enqueued. A monitor on the falling edge follows each frame by its age
// since the pop and compares tx/busy/byte_done/bytes_sent against the frame
// built from the scoreboard byte.
module tb_fifo_uart_drain;
  localparam int CPB = 4;
  localparam int CW  = 2;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB + 2;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          enable     = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [7:0]    fifo_dout  = 8'h00;
  logic          fifo_pop;
  logic          tx;
  logic          busy;
  logic          byte_done;
  logic [CW-1:0] bytes_sent;

  fifo_uart_drain #(.CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_fifo_empty(fifo_empty),
    .i_fifo_dout(fifo_dout), .o_fifo_pop(fifo_pop), .o_tx(tx), .o_busy(busy),
    .o_byte_done(byte_done), .o_bytes_sent(bytes_sent)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame bits in transmit order: start, data LSB first, [parity], stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f = 11'h7FF;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = b[i];
`ifdef UART_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         fifo_n;

  // FIFO model: one-cycle read latency, empty flag follows queue occupancy.
  always @(posedge clk) begin
    fifo_n = fifo_q.size();
    if (fifo_pop) begin
      chk("pop_nonempty", 32'(fifo_n > 0), 32'd1);
      if (fifo_n > 0) begin
        fifo_dout <= fifo_q.pop_front();
        fifo_n = fifo_n - 1;
      end
    end
    fifo_empty <= (fifo_n == 0);
  end

  logic rst_at_edge = 1'b1;
  int   cyc = 0;
  always @(posedge clk) begin
    rst_at_edge <= rst;
    cyc <= cyc + 1;
  end

  logic        in_frame   = 1'b0;
  int          k          = 0;
  logic        prev_ok    = 1'b0;
  int          n_pops     = 0;
  int          model_sent = 0;
  logic [10:0] fbits      = 11'h7FF;
  logic [7:0]  cur        = 8'h00;
  logic        exp_tx;

  // Monitor / scoreboard checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_at_edge) begin
        in_frame   = 1'b0;
        prev_ok    = 1'b0;
        model_sent = 0;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pop", 32'(fifo_pop), 32'd0);
        chk("rst_done", 32'(byte_done), 32'd0);
        chk("rst_sent", 32'(bytes_sent), 32'd0);
      end else begin
        if (in_frame) k = k + 1;
        chk("pop_timing", 32'(fifo_pop), 32'(prev_ok));
        if (fifo_pop) begin
          n_pops++;
          if (in_frame) chk("pop_spacing", 32'(k), 32'(FLEN));
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          chk("sb_has_byte", 32'(exp_q.size() + 1 > 0), 32'd1);
          fbits    = frame_of(cur);
          in_frame = 1'b1;
          k        = 0;
        end else if (in_frame && k == FLEN) begin
          in_frame = 1'b0;
        end
        if (in_frame) begin
          exp_tx = (k < 2) ? 1'b1 : fbits[(k - 2) / CPB];
          if (k == FLEN - 1) model_sent++;
          chk("tx", 32'(tx), 32'(exp_tx));
          chk("busy", 32'(busy), 32'd1);
          chk("byte_done", 32'(byte_done), 32'(k == FLEN - 1));
        end else begin
          chk("idle_tx", 32'(tx), 32'd1);
          chk("idle_busy", 32'(busy), 32'd0);
          chk("idle_done", 32'(byte_done), 32'd0);
        end
        chk("bytes_sent", 32'(bytes_sent), 32'(model_sent % (1 << CW)));
        prev_ok = enable && !fifo_empty && (!in_frame || k == FLEN - 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_drained(input int budget, input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_frame) && t < budget) begin
      tick(1);
      t++;
    end
    chk(name, 32'(t < budget), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t;
    int pops0;
    int nb;
    rst = 1'b1;
    enable = 1'b1;
    tick(3);
    rst = 1'b0;

    // Empty FIFO with enable high: never pops, line stays idle.
    tick(100);
    chk("idle_no_pop", 32'(n_pops), 32'd0);

    // Single byte.
    push(8'hA5);
    wait_drained(200, "drain_a5");
    chk("sent_after_a5", 32'(bytes_sent), 32'd1);

    // Parity-sensitive pair (odd / even number of ones).
    push(8'h07);
    push(8'h03);
    wait_drained(300, "drain_07_03");

    // Back-to-back from a fresh reset.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    pops0 = n_pops;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    wait_drained(500, "drain_b2b");
    chk("b2b_pops", 32'(n_pops - pops0), 32'd3);
    chk("b2b_sent", 32'(bytes_sent), 32'd3);

    // Enable dropped during the data bits of the first of two bytes.
    pops0 = n_pops;
    push(8'h3C);
    push(8'hC3);
    t = 0;
    while (!(in_frame && k >= 12) && t < 100) begin tick(1); t++; end
    chk("reach_data_en", 32'(t < 100), 32'd1);
    enable = 1'b0;
    t = 0;
    while (in_frame && t < 100) begin tick(1); t++; end
    chk("frame1_completes", 32'(t < 100), 32'd1);
    tick(50);
    chk("en_low_pops", 32'(n_pops - pops0), 32'd1);
    chk("en_low_sent", 32'(bytes_sent), 32'd0);
    enable = 1'b1;
    wait_drained(200, "drain_en_resume");
    chk("en_resume_pops", 32'(n_pops - pops0), 32'd2);
    chk("wrap_sent", 32'(bytes_sent), 32'd1);

    // Reset in the middle of the data bits drops the frame.
    push(8'h96);
    t = 0;
    while (!(in_frame && k >= 14) && t < 100) begin tick(1); t++; end
    chk("reach_data_rst", 32'(t < 100), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    chk("rst_mid_sent", 32'(bytes_sent), 32'd0);
    chk("rst_mid_tx", 32'(tx), 32'd1);

    // Randomised traffic with enable toggling.
    for (int it = 0; it < 25; it++) begin
      nb = $urandom_range(0, 3);
      for (int j = 0; j < nb; j++) push(8'($urandom));
      enable = ($urandom_range(0, 3) != 0);
      tick($urandom_range(5, 120));
    end
    enable = 1'b1;
    wait_drained(5000, "drain_random");
    tick(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_uart_drain.md
# fifo_uart_drain

Downstream stage of the SPI ADC + FIFO wrapper: drains 8-bit ADC samples from the sample FIFO and serialises each one as an asynchronous UART frame (8N1, optional even parity) for off-board logging. It owns the FIFO pop strobe and issues exactly one pop per transmitted byte. All logic runs on one clock with a per-bit baud counter; no oversampling and no receive path.

## Interface
- CLKS_PER_BIT, 434 — clock cycles per UART bit (434 = 115200 baud at 50 MHz); legal range 2..65535
- CNT_W, 16 — width of the bytes_sent counter
- clk  input  1  system clock; all logic rising-edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  level; when 0, no new byte is popped (frame in progress completes)
- fifo_empty  input  1  FIFO empty flag
- fifo_dout  input  8  FIFO read data; valid the cycle after fifo_pop is asserted
- fifo_pop  output  1  single-cycle FIFO pop strobe
- tx  output  1  UART serial line, idle high
- busy  output  1  high from the pop cycle through the last stop-bit cycle
- byte_done  output  1  single-cycle pulse on the last cycle of the stop bit
- bytes_sent  output  CNT_W  count of completed frames, wraps modulo 2^CNT_W

## Operation
- Single clock; reset is synchronous and active-high (clk, rst).
- States: IDLE, FETCH, START, DATA, PARITY (only with the macro), STOP.
- IDLE: tx=1, busy=0. If enable=1 and fifo_empty=0, drive fifo_pop=1 for this cycle and go to FETCH.
- FETCH: one cycle; busy=1; capture fifo_dout into the shift register at the end of the cycle; go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit index selects the bit.
- PARITY: tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles; byte_done=1 and bytes_sent increments on its last cycle; go to IDLE.
- The baud counter runs 0..CLKS_PER_BIT-1 and reloads to 0 on every bit transition.
- enable is sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- fifo_empty is sampled only in IDLE. The block never pops while the FIFO is empty.
- bytes_sent wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-frame: on the next edge state=IDLE, tx=1, and the frame is dropped with no byte_done. The popped byte is lost.

## Timing
- Reset values: tx=1, fifo_pop=0, busy=0, byte_done=0, bytes_sent=0, state=IDLE.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Pop to start-bit edge: pop in cycle N, FETCH in N+1, tx falls at the edge starting N+2.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity), plus 2 overhead cycles (IDLE pop + FETCH).
- Back-to-back: with the FIFO non-empty, the next pop occurs in the IDLE cycle right after STOP. tx stays high for exactly 2 extra cycles between frames.
- byte_done and the bytes_sent update coincide with the last STOP cycle. busy drops on the following cycle.

## Configuration
- UART_PARITY_EN defined: the PARITY state is inserted between DATA and STOP (even parity; frame = 11 bit times).
- UART_PARITY_EN undefined: the PARITY state and its XOR logic are absent; 8N1 frame = 10 bit times.

## Test plan
- Reset check, CLKS_PER_BIT=4: hold rst 3 cycles -> tx=1, busy=0, fifo_pop=0, bytes_sent=0. With fifo_empty=1 and enable=1 for 100 cycles -> no pop, tx stays 1.
- Single byte 8'hA5, CLKS_PER_BIT=4, no parity: one pop -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles. Start edge 2 cycles after pop; one byte_done; bytes_sent=1.
- UART_PARITY_EN, byte 8'h07: parity bit = 1; frame = 44 cycles; byte 8'h03 gives parity bit 0.
- Back-to-back, 3 bytes queued (8'h00, 8'hFF, 8'h55): exactly 3 pops, 2 tx-high cycles between stop bit and next start bit, bytes_sent=3.
- enable dropped during DATA of byte 1 with 2 bytes queued: byte 1 completes, no further pop until enable returns, then byte 2 is sent.
- Reset asserted mid-DATA: tx=1 next cycle, no byte_done, bytes_sent=0. CNT_W=2 with 5 frames sent -> bytes_sent=1 (wrap).
